// File: rtl/tinyodin_obi_loader.sv
// OBI master that loads the tinyODIN charge core memory map from region/index/length commands,
// issuing one single-word write at a time in fill (replicated word) or stream (one beat/word) mode.
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module tinyodin_obi_loader (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_region_i,
  input  logic [12:0]        cmd_index_i,
  input  logic [12:0]        cmd_len_i,
  input  logic               cmd_fill_i,
  input  logic [31:0]        cmd_fill_data_i,
  input  logic               data_valid_i,
  output logic               data_ready_o,
  input  logic [31:0]        data_i,
  output obi_pkg::obi_req_t  tinyODIN_master_req_o,
  input  obi_pkg::obi_resp_t tinyODIN_master_resp_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  input  logic               err_clr_i
);

  typedef enum logic [1:0] {StIdle, StFetch, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  region_q, region_d;
  logic [12:0] index_q, index_d;
  logic [12:0] remain_q, remain_d;
  logic        fill_q, fill_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [13:0] end_idx;
  logic [13:0] limit;
  logic        in_range;
  logic        unused_rdata;

  assign unused_rdata = ^tinyODIN_master_resp_i.rdata;

  // Last legal word index per region; the single control word forces index=0 and len=0.
  always_comb begin
    unique case (cmd_region_i)
      2'b00:   limit = 14'd63;
      2'b01:   limit = 14'd255;
      2'b10:   limit = 14'd8191;
      default: limit = 14'd0;
    endcase
  end

  assign end_idx  = {1'b0, cmd_index_i} + {1'b0, cmd_len_i};
  assign in_range = (end_idx <= limit);

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    index_d  = index_q;
    remain_d = remain_q;
    fill_d   = fill_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = err_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else begin
            region_d = cmd_region_i;
            index_d  = cmd_index_i;
            remain_d = cmd_len_i;
            fill_d   = cmd_fill_i;
            wdata_d  = cmd_fill_data_i;
            state_d  = cmd_fill_i ? StReq : StFetch;
          end
        end
      end
      StFetch: begin
        if (data_valid_i) begin
          wdata_d = data_i;
          state_d = StReq;
        end
      end
      StReq: begin
        if (tinyODIN_master_resp_i.gnt) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (tinyODIN_master_resp_i.rvalid) begin
          if (remain_q == 13'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            index_d  = index_q + 13'd1;
            remain_d = remain_q - 13'd1;
            state_d  = fill_q ? StReq : StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request fields are zero outside REQ so stale addresses never leak onto the bus.
  always_comb begin
    tinyODIN_master_req_o = '0;
    if (state_q == StReq) begin
      tinyODIN_master_req_o.req   = 1'b1;
      tinyODIN_master_req_o.we    = 1'b1;
      tinyODIN_master_req_o.be    = 4'hF;
      tinyODIN_master_req_o.addr  = {10'b0, region_q, 5'b0, index_q, 2'b00};
      tinyODIN_master_req_o.wdata = wdata_q;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign data_ready_o = (state_q == StFetch);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign err_o        = err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      region_q <= 2'b00;
      index_q  <= 13'd0;
      remain_q <= 13'd0;
      fill_q   <= 1'b0;
      wdata_q  <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      index_q  <= index_d;
      remain_q <= remain_d;
      fill_q   <= fill_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_tinyodin_obi_loader.sv
// Self-checking bench for tinyodin_obi_loader: OBI slave responder with random grant delay,
// stream data source with random gaps, and an expected-write queue built from region arithmetic.
module tb_tinyodin_obi_loader;
  import obi_pkg::*;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_fill;
  logic [1:0]  cmd_region;
  logic [12:0] cmd_index, cmd_len;
  logic [31:0] cmd_fill_data;
  logic        data_valid, data_ready;
  logic [31:0] data_in;
  obi_req_t    obi_req;
  obi_resp_t   obi_rsp;
  logic        gnt, rvalid;
  logic        busy, done, err, err_clr;

  assign obi_rsp = {gnt, rvalid, 32'hdead_beef};

  tinyodin_obi_loader dut (
    .CLK                    (clk),
    .RST                    (rst),
    .cmd_valid_i            (cmd_valid),
    .cmd_ready_o            (cmd_ready),
    .cmd_region_i           (cmd_region),
    .cmd_index_i            (cmd_index),
    .cmd_len_i              (cmd_len),
    .cmd_fill_i             (cmd_fill),
    .cmd_fill_data_i        (cmd_fill_data),
    .data_valid_i           (data_valid),
    .data_ready_o           (data_ready),
    .data_i                 (data_in),
    .tinyODIN_master_req_o  (obi_req),
    .tinyODIN_master_resp_i (obi_rsp),
    .busy_o                 (busy),
    .done_o                 (done),
    .err_o                  (err),
    .err_clr_i              (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: region depth and word address from plain arithmetic.
  function automatic int depth_of(input int r);
    case (r)
      0:       return 64;
      1:       return 256;
      2:       return 8192;
      default: return 1;
    endcase
  endfunction

  function automatic bit range_ok(input int r, input int idx, input int len);
    return (idx + len) < depth_of(r);
  endfunction

  function automatic logic [31:0] word_addr(input int r, input int w);
    return 32'(r * 32'h0010_0000 + w * 4);
  endfunction

  logic [31:0] exp_addr[$];
  logic [31:0] exp_wdata[$];
  logic [31:0] sdata[$];

  int maxd = 0, gap_pct = 0, grant_limit = 32'h7fff_ffff;
  int wr_cnt = 0, done_cnt = 0, done_edge = 0, dly = 0;
  bit rdy_at_done, waiting, pend_rv, outst, stall;
  logic [31:0] prev_addr, prev_wdata, last_addr;

  // OBI slave + stream source + write checker; all decisions at negedge.
  initial begin : responder
    gnt = 1'b0; rvalid = 1'b0; data_valid = 1'b0; data_in = '0;
    waiting = 0; pend_rv = 0; outst = 0; stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        gnt = 1'b0; rvalid = 1'b0; data_valid = 1'b0;
        waiting = 0; pend_rv = 0; outst = 0; stall = 0;
      end else begin
        if (rvalid) outst = 0;
        if (gnt) outst = 1;
        if (done) begin
          done_cnt++;
          done_edge = edge_cnt;
          rdy_at_done = cmd_ready;
        end
        chk("data_ready_only_fetch", 32'(data_ready & (obi_req.req | ~busy | outst)), 32'd0);
        if (stall) begin
          chk("req_held_until_gnt", 32'(obi_req.req), 32'd1);
          chk("addr_stable", obi_req.addr, prev_addr);
          chk("wdata_stable", obi_req.wdata, prev_wdata);
        end
        rvalid = pend_rv;
        pend_rv = 0;
        gnt = 1'b0;
        stall = 0;
        if (obi_req.req && wr_cnt < grant_limit) begin
          if (!waiting) begin
            waiting = 1;
            dly = $urandom_range(0, maxd);
          end
          if (dly == 0) begin
            gnt = 1'b1; waiting = 0; pend_rv = 1; wr_cnt++;
            chk("write_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) begin
              chk("wr_addr", obi_req.addr, exp_addr.pop_front());
              chk("wr_wdata", obi_req.wdata, exp_wdata.pop_front());
              chk("wr_we_be", {27'd0, obi_req.we, obi_req.be}, 32'h1F);
            end
            last_addr = obi_req.addr;
          end else begin
            dly--;
          end
        end
        if (obi_req.req && !gnt) begin
          stall = 1;
          prev_addr = obi_req.addr;
          prev_wdata = obi_req.wdata;
        end
        data_valid = 1'b0;
        if (sdata.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
          data_valid = 1'b1;
          data_in = sdata[0];
          if (data_ready) void'(sdata.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_addr.delete(); exp_wdata.delete(); sdata.delete();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(obi_req.req), 32'd0);
    chk({tag, "_we_be"}, {27'd0, obi_req.we, obi_req.be}, 32'd0);
    chk({tag, "_addr"}, obi_req.addr, 32'd0);
    chk({tag, "_wdata"}, obi_req.wdata, 32'd0);
    chk({tag, "_ready_busy_done_err"}, {27'd0, cmd_ready, data_ready, busy, done, err}, 32'h10);
  endtask

  task automatic clr_err();
    @(negedge clk); #1 err_clr = 1'b1;
    @(negedge clk); #1 err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
  endtask

  // Queues the model's writes/data, then performs the command handshake; returns accept edge.
  task automatic issue_cmd(input int r, input int idx, input int len, input bit fill,
                           input logic [31:0] fdata, input bit exp_err, input bit clr_same,
                           output int a);
    int budget;
    if (!exp_err) begin
      for (int i = 0; i <= len; i++) begin
        logic [31:0] w;
        w = (fill || i == 0) ? fdata : $urandom();
        exp_addr.push_back(word_addr(r, idx + i));
        exp_wdata.push_back(w);
        if (!fill) sdata.push_back(w);
      end
    end
    @(negedge clk); #1;
    budget = 20;
    while (!cmd_ready && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_region = 2'(r); cmd_index = 13'(idx); cmd_len = 13'(len);
    cmd_fill = fill; cmd_fill_data = fdata; err_clr = clr_same;
    @(negedge clk); #1;
    a = edge_cnt;
    cmd_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic run_cmd(input int r, input int idx, input int len, input bit fill,
                         input logic [31:0] fdata, input bit exp_err, input int exp_cyc,
                         input bit clr_same);
    int a, budget, done0;
    bit got;
    done0 = done_cnt;
    issue_cmd(r, idx, len, fill, fdata, exp_err, clr_same, a);
    if (exp_err) begin
      chk("err_after_bad_cmd", 32'(err), 32'd1);
      chk("idle_after_bad_cmd", 32'(busy), 32'd0);
      @(negedge clk); #1;
      chk("no_done_on_err", 32'(done_cnt - done0), 32'd0);
    end else begin
      chk("busy_after_accept", 32'(busy), 32'd1);
      budget = (len + 1) * 16 + 64;
      got = 0;
      while (budget > 0 && !got) begin
        if (done_cnt != done0) got = 1;
        else begin
          @(negedge clk); #1;
          budget--;
        end
      end
      chk("done_seen", 32'(got), 32'd1);
      if (got) begin
        if (exp_cyc >= 0) chk("done_latency", 32'(done_edge - a), 32'(exp_cyc));
        chk("ready_with_done", 32'(rdy_at_done), 32'd1);
        @(negedge clk); #1;
        chk("done_once", 32'(done_cnt - done0), 32'd1);
        chk("writes_all_issued", 32'(exp_addr.size()), 32'd0);
      end else begin
        do_reset();
      end
    end
  endtask

  typedef struct {
    int          region;
    int          index;
    int          len;
    bit          fill;
    logic [31:0] fdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #900000;
    failures++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int a, done0, budget;
    vecs[0] = '{0, 60, 4, 1'b1, 32'h0, 1'b1};
    vecs[1] = '{0, 36, 27, 1'b1, 32'h1234_5678, 1'b0};
    vecs[2] = '{3, 0, 0, 1'b1, 32'hFF00_0400, 1'b0};
    vecs[3] = '{3, 0, 1, 1'b1, 32'hFF00_0400, 1'b1};
    vecs[4] = '{3, 1, 0, 1'b1, 32'h1, 1'b1};
    vecs[5] = '{1, 250, 5, 1'b0, 32'hCAFE_0001, 1'b0};
    vecs[6] = '{1, 250, 6, 1'b1, 32'h0, 1'b1};
    vecs[7] = '{2, 8191, 0, 1'b1, 32'h5A5A_A5A5, 1'b0};
    vecs[8] = '{2, 8191, 8191, 1'b1, 32'h0, 1'b1};
    vecs[9] = '{0, 0, 63, 1'b0, 32'h0BAD_F00D, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_region = '0; cmd_index = '0; cmd_len = '0;
    cmd_fill = 1'b0; cmd_fill_data = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_vals("rst_held");
    rst = 1'b0;
    @(negedge clk); #1;
    chk_reset_vals("rst_released");

    // Full synapse zeroing, 2 cycles per word.
    maxd = 0; gap_pct = 0;
    run_cmd(2, 0, 8191, 1'b1, 32'h0, 1'b0, 16384, 1'b0);
    chk("synapse_last_addr", last_addr, 32'h0020_7FFC);

    maxd = 3; gap_pct = 40;
    run_cmd(1, 0, 255, 1'b0, 32'h0015_E000, 1'b0, -1, 1'b0);
    chk("neuron_last_addr", last_addr, 32'h0010_03FC);

    // Stream throughput with data always valid: 3 cycles per word.
    maxd = 0; gap_pct = 0;
    run_cmd(0, 0, 3, 1'b0, $urandom(), 1'b0, 12, 1'b0);

    for (int i = 0; i < 10; i++) begin
      maxd = $urandom_range(0, 3); gap_pct = $urandom_range(0, 50);
      run_cmd(vecs[i].region, vecs[i].index, vecs[i].len, vecs[i].fill, vecs[i].fdata,
              vecs[i].exp_err, -1, 1'b0);
      if (i == 1) chk("spike_last_addr", last_addr, 32'h0000_00FC);
      if (i == 2) chk("control_addr", last_addr, 32'h0030_0000);
      if (vecs[i].exp_err) clr_err();
    end

    // Error event and clear in the same cycle: error wins.
    run_cmd(3, 0, 1, 1'b1, 32'h0, 1'b1, -1, 1'b1);
    clr_err();

    for (int k = 0; k < 24; k++) begin
      int r, t, ln;
      bit ok;
      r = $urandom_range(0, 3);
      maxd = $urandom_range(0, 3); gap_pct = $urandom_range(0, 60);
      ln = (r == 3) ? $urandom_range(0, 1) : $urandom_range(0, 12);
      t = depth_of(r) - 1 - $urandom_range(0, 16);
      if (t < 0) t = 0;
      ok = range_ok(r, t, ln);
      run_cmd(r, t, ln, 1'(($urandom() & 1)), $urandom(), !ok, -1, 1'b0);
      if (!ok) clr_err();
    end

    // Reset during the 5th REQ of a fill, with a sticky error pending.
    run_cmd(0, 60, 4, 1'b1, 32'h0, 1'b1, -1, 1'b0);
    maxd = 0;
    grant_limit = wr_cnt + 4;
    done0 = done_cnt;
    issue_cmd(0, 0, 9, 1'b1, 32'hA5A5_0000, 1'b0, 1'b0, a);
    budget = 200;
    while (!(wr_cnt == grant_limit && obi_req.req) && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk("fifth_req_reached", 32'(obi_req.req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("req_drops_async", 32'(obi_req.req), 32'd0);
    chk("busy_drops_async", 32'(busy), 32'd0);
    do_reset();
    grant_limit = 32'h7fff_ffff;
    @(negedge clk); #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt - done0), 32'd0);
    run_cmd(3, 0, 0, 1'b1, 32'hFF00_0400, 1'b0, 2, 1'b0);
    chk("post_rst_control_addr", last_addr, 32'h0030_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
